// File: rtl/bram_port_arbiter_if.sv
// ============================================================================
// Module   : bram_port_arbiter_if
// Brief    : Requester-side bundle of the shared BRAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bram_port_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ-1:0]            req_lock;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

`default_nettype wire

// File: rtl/bram_port_arbiter.sv
// ============================================================================
// Module   : bram_port_arbiter
// Brief    : Round-robin arbiter sharing one BRAM port, with burst lock,
//            registered BRAM drive and tagged read-data return.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_port_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    bram_port_arbiter_if.slave         req_if,
    output logic                       bram_en,
    output logic                       bram_we,
    output logic [ADDR_WIDTH-1:0]      bram_addr,
    output logic [DATA_WIDTH-1:0]      bram_wdata,
    input  wire logic [DATA_WIDTH-1:0] bram_rdata,
    output logic                       busy
);

    localparam int C_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [C_IDX_W:0] C_NUM_REQ = (C_IDX_W+1)'(NUM_REQ);

    typedef enum logic [0:0] {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t            r_state;
    lock_state_t            w_state_next;
    logic [C_IDX_W-1:0]     r_owner;
    logic [C_IDX_W-1:0]     w_owner_next;
    logic [C_IDX_W-1:0]     r_ptr;
    logic [C_IDX_W-1:0]     w_ptr_next;

    logic [NUM_REQ-1:0]     w_owner_mask;
    logic                   w_owner_lock;
    logic [NUM_REQ-1:0]     w_eligible;
    logic [NUM_REQ-1:0]     w_ready;
    logic [C_IDX_W-1:0]     w_gidx;
    logic                   w_found;
    logic                   w_hs;

    logic                   w_sel_we;
    logic                   w_sel_lock;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [DATA_WIDTH-1:0]  w_sel_wdata;
    logic [NUM_REQ-1:0]     w_push;
    logic                   w_tag_pending;

    logic                   r_en;
    logic                   r_we;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [DATA_WIDTH-1:0]  r_rsp_data;
    logic                   r_busy;
    // One-hot requester tag per stage; stage READ_LATENCY lines up with BRAM data.
    logic [NUM_REQ-1:0]     r_tag [0:READ_LATENCY];

    // While locked only the owner may be granted, even if it is idle.
    always_comb begin
        w_owner_mask = NUM_REQ'(1) << r_owner;
        w_owner_lock = |(req_if.req_lock & w_owner_mask);
        w_eligible   = (r_state == ST_LOCKED) ? (req_if.req_valid & w_owner_mask)
                                              : req_if.req_valid;
    end

    always_comb begin
        logic [C_IDX_W:0] v_idx;
        w_found = 1'b0;
        w_gidx  = '0;
        v_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = {1'b0, r_ptr} + (C_IDX_W+1)'(k);
            if (v_idx >= C_NUM_REQ) begin
                v_idx = v_idx - C_NUM_REQ;
            end
            if (!w_found && w_eligible[v_idx[C_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = v_idx[C_IDX_W-1:0];
            end
        end
        w_ready = (w_found && reset) ? (NUM_REQ'(1) << w_gidx) : '0;
        w_hs    = |w_ready;
    end

    always_comb begin
        logic [C_IDX_W:0] v_inc;
        v_inc      = {1'b0, w_gidx} + (C_IDX_W+1)'(1);
        w_ptr_next = (v_inc >= C_NUM_REQ) ? '0 : v_inc[C_IDX_W-1:0];
    end

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_lock  = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_ready[i]) begin
                w_sel_we    = req_if.req_we[i];
                w_sel_lock  = req_if.req_lock[i];
                w_sel_addr  = req_if.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = req_if.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        w_push = w_ready & ~req_if.req_we;
    end

    always_comb begin
        w_tag_pending = 1'b0;
        for (int s = 0; s < READ_LATENCY; s++) begin
            w_tag_pending = w_tag_pending | (|r_tag[s]);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        case (r_state)
            ST_OPEN: begin
                if (w_hs && w_sel_lock) begin
                    w_state_next = ST_LOCKED;
                    w_owner_next = w_gidx;
                end
            end
            ST_LOCKED: begin
                if (!w_owner_lock) begin
                    w_state_next = ST_OPEN;
                end
            end
            default: w_state_next = ST_OPEN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_OPEN;
            r_owner <= '0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr      <= '0;
            r_en       <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
            r_busy     <= 1'b0;
            for (int s = 0; s <= READ_LATENCY; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_en   <= w_hs;
            r_we   <= w_hs & w_sel_we;
            r_busy <= (w_state_next == ST_LOCKED) | (|w_push) | w_tag_pending;
            if (w_hs) begin
                r_ptr   <= w_ptr_next;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            r_tag[0] <= w_push;
            for (int s = 1; s <= READ_LATENCY; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
            if (|r_tag[READ_LATENCY]) begin
                r_rsp_data <= bram_rdata;
            end
        end
    end

    // BRAM data arrives in the response cycle itself, so it is forwarded then
    // and the captured copy is held between responses.
    assign req_if.req_ready = w_ready;
    assign req_if.rsp_valid = r_tag[READ_LATENCY];
    assign req_if.rsp_data  = (|r_tag[READ_LATENCY]) ? bram_rdata : r_rsp_data;
    assign bram_en          = r_en;
    assign bram_we          = r_we;
    assign bram_addr        = r_addr;
    assign bram_wdata       = r_wdata;
    assign busy             = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
// ============================================================================
// Module   : tb_bram_port_arbiter
// Brief    : Directed self-checking bench; two arbiters (latency 1 and 2)
//            share one stimulus, each with its own synchronous BRAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    bram_port_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(10), .DATA_WIDTH(8)) bif ();
    bram_port_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(10), .DATA_WIDTH(8)) bif2 ();

    assign bif2.req_valid = bif.req_valid;
    assign bif2.req_we    = bif.req_we;
    assign bif2.req_lock  = bif.req_lock;
    assign bif2.req_addr  = bif.req_addr;
    assign bif2.req_wdata = bif.req_wdata;

    logic       en1, we1, busy1, en2, we2, busy2;
    logic [9:0] addr1, addr2;
    logic [7:0] wd1, wd2, rd1, rd2;

    bram_port_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(10), .DATA_WIDTH(8), .READ_LATENCY(1)) u_dut (
        .clk(clk), .reset(rst_n), .req_if(bif),
        .bram_en(en1), .bram_we(we1), .bram_addr(addr1), .bram_wdata(wd1),
        .bram_rdata(rd1), .busy(busy1)
    );

    bram_port_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(10), .DATA_WIDTH(8), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .reset(rst_n), .req_if(bif2),
        .bram_en(en2), .bram_we(we2), .bram_addr(addr2), .bram_wdata(wd2),
        .bram_rdata(rd2), .busy(busy2)
    );

    // Read-first synchronous BRAMs: 1 and 2 output register stages.
    logic [7:0] mem1 [0:1023];
    logic [7:0] mem2 [0:1023];
    logic [7:0] m2_s1;
    always @(posedge clk) begin
        if (en1) begin
            if (we1) mem1[addr1] <= wd1;
            rd1 <= mem1[addr1];
        end
        if (en2) begin
            if (we2) mem2[addr2] <= wd2;
            m2_s1 <= mem2[addr2];
        end
        rd2 <= m2_s1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bif.req_valid = '0;
        bif.req_we    = '0;
        bif.req_lock  = '0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;
    endtask

    task automatic drive(input int i, input logic v, input logic we, input logic lk,
                         input logic [9:0] a, input logic [7:0] d);
        bif.req_valid[i]        = v;
        bif.req_we[i]           = we;
        bif.req_lock[i]         = lk;
        bif.req_addr[i*10 +: 10] = a;
        bif.req_wdata[i*8 +: 8]  = d;
    endtask

    logic [2:0] exp_gnt [0:5];
    logic [9:0] rr_addr [0:2];

    initial begin
        exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rr_addr = '{10'd5, 10'd6, 10'd7};
        rst_n = 1'b0;
        idle_all();
        bif.req_valid = 3'($urandom) | 3'b001;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 32'(bif.req_ready), 0);
        chk("reset_en", 32'(en1), 0);
        chk("reset_rsp", 32'(bif.rsp_valid), 0);
        chk("reset_busy", 32'(busy1), 0);
        chk("reset_addr", 32'(addr1), 0);
        idle_all();
        rst_n = 1'b1;

        // Round robin with all three requesters writing continuously
        tick();
        drive(0, 1, 1, 0, 10'd5, 8'h3C);
        drive(1, 1, 1, 0, 10'd6, 8'h55);
        drive(2, 1, 1, 0, 10'd7, 8'hAA);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            #1;
            if (k > 0) begin
                chk("rr_en", 32'(en1), 1);
                chk("rr_addr", 32'(addr1), 32'(rr_addr[(k-1)%3]));
            end
            chk("rr_ready", 32'(bif.req_ready), 32'(exp_gnt[k]));
        end
        tick(); idle_all(); #1;
        chk("rr_tail_addr", 32'(addr1), 7);
        chk("rr_idle_ready", 32'(bif.req_ready), 0);
        tick(); #1;
        chk("idle_en", 32'(en1), 0);
        chk("idle_addr_hold", 32'(addr1), 7);

        // Single read by requester 1
        tick(); drive(1, 1, 0, 0, 10'd5, 8'h00); #1;
        chk("rd_ready", 32'(bif.req_ready), 32'b010);
        tick(); idle_all(); #1;
        chk("rd_en", 32'(en1), 1);
        chk("rd_we", 32'(we1), 0);
        chk("rd_addr", 32'(addr1), 5);
        chk("rd_rsp_early", 32'(bif.rsp_valid), 0);
        tick(); #1;
        chk("rd_rsp", 32'(bif.rsp_valid), 32'b010);
        chk("rd_data", 32'(bif.rsp_data), 32'h3C);
        chk("rd_rsp2_early", 32'(bif2.rsp_valid), 0);
        tick(); #1;
        chk("rd_rsp_gone", 32'(bif.rsp_valid), 0);
        chk("rd_rsp2", 32'(bif2.rsp_valid), 32'b010);
        chk("rd_data2", 32'(bif2.rsp_data), 32'h3C);

        // Requester 2 single write moves the pointer back to 0
        tick(); drive(2, 1, 1, 0, 10'd20, 8'h01); #1;
        chk("ptr_ready", 32'(bif.req_ready), 32'b100);

        // Locked 4-beat burst by requester 0 while requester 2 waits
        for (int b = 0; b < 4; b++) begin
            tick();
            idle_all();
            drive(0, 1, 1, (b < 3), 10'(10 + b), 8'(8'hA0 + b));
            drive(2, 1, 1, 0, 10'd30, 8'h33);
            #1;
            chk("lk_ready", 32'(bif.req_ready), 32'b001);
            if (b > 0) chk("lk_busy", 32'(busy1), 1);
        end
        tick(); idle_all(); drive(2, 1, 1, 0, 10'd30, 8'h33); #1;
        chk("lk_release_ready", 32'(bif.req_ready), 32'b100);
        chk("lk_busy_end", 32'(busy1), 0);
        chk("lk_last_addr", 32'(addr1), 13);
        chk("lk_last_wdata", 32'(wd1), 32'hA3);
        tick(); idle_all(); #1;
        chk("lk_after_addr", 32'(addr1), 30);

        // Write then read of the same address on consecutive cycles
        tick(); drive(2, 1, 1, 0, 10'd9, 8'h7F); #1;
        chk("wr_ready", 32'(bif.req_ready), 32'b100);
        tick(); idle_all(); drive(1, 1, 0, 0, 10'd9, 8'h00); #1;
        chk("war_ready", 32'(bif.req_ready), 32'b010);
        tick(); idle_all(); #1;
        tick(); #1;
        chk("war_rsp", 32'(bif.rsp_valid), 32'b010);
        chk("war_data", 32'(bif.rsp_data), 32'h7F);
        chk("war_rsp2_early", 32'(bif2.rsp_valid), 0);
        tick(); #1;
        chk("war_rsp2", 32'(bif2.rsp_valid), 32'b010);
        chk("war_data2", 32'(bif2.rsp_data), 32'h7F);
        chk("war_rsp_gone", 32'(bif.rsp_valid), 0);

        // Two locked reads in flight, then a one-cycle reset pulse
        tick(); drive(0, 1, 0, 1, 10'd5, 8'h00); #1;
        chk("mr_ready0", 32'(bif.req_ready), 32'b001);
        tick(); drive(0, 1, 0, 1, 10'd6, 8'h00); #1;
        chk("mr_ready1", 32'(bif.req_ready), 32'b001);
        chk("mr_busy", 32'(busy1), 1);
        tick(); idle_all(); bif.req_valid = 3'b111; rst_n = 1'b0; #1;
        chk("mr_rst_ready", 32'(bif.req_ready), 0);
        chk("mr_rst_rsp", 32'(bif.rsp_valid), 0);
        chk("mr_rst_rsp2", 32'(bif2.rsp_valid), 0);
        chk("mr_rst_busy2", 32'(busy2), 0);
        tick(); rst_n = 1'b1; idle_all();
        drive(1, 1, 1, 0, 10'd40, 8'h00);
        drive(2, 1, 1, 0, 10'd41, 8'h00);
        #1;
        chk("mr_post_ready", 32'(bif.req_ready), 32'b010);
        chk("mr_post_rsp", 32'(bif.rsp_valid), 0);
        chk("mr_post_rsp2", 32'(bif2.rsp_valid), 0);
        chk("mr_post_busy", 32'(busy1), 0);
        tick(); idle_all(); #1;
        chk("mr_late_rsp2", 32'(bif2.rsp_valid), 0);
        tick(); #1;
        chk("mr_late_rsp2b", 32'(bif2.rsp_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one BRAM port between up to NUM_REQ requesters. Typical requesters are the input controller, the LLR calculator and the partial-sum calculator; the shared port is the LLR-init or partial-sum BRAM port A.
- Replaces the ad-hoc state-based address/enable muxing at the decoder top with a round-robin arbiter, lockable bursts, registered BRAM drive and tagged read-data return.
- Sits between the requesters and the BRAM wrapper inside the polar decoder.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_WIDTH, 10, BRAM address width.
- DATA_WIDTH, 8, BRAM data width (8 for LLR, 1 for partial sum).
- READ_LATENCY, 1, BRAM clock-to-data latency in cycles (1..3; 1 when READ_REG_ENABLE=0).

Ports:
- clk, input, 1, single clock, rising edge.
- reset, input, 1, asynchronous, active-low reset.
- req_valid, input, NUM_REQ, access request per requester.
- req_ready, output, NUM_REQ, grant; a handshake occurs when req_valid[i] & req_ready[i].
- req_we, input, NUM_REQ, 1 = write, 0 = read.
- req_lock, input, NUM_REQ, hold the grant across consecutive accesses (burst).
- req_addr, input, NUM_REQ*ADDR_WIDTH, packed address; slice i belongs to requester i.
- req_wdata, input, NUM_REQ*DATA_WIDTH, packed write data.
- rsp_valid, output, NUM_REQ, read data valid for requester i.
- rsp_data, output, DATA_WIDTH, read data, shared by all requesters.
- bram_en, output, 1, BRAM enable.
- bram_we, output, 1, BRAM write enable.
- bram_addr, output, ADDR_WIDTH, BRAM address.
- bram_wdata, output, DATA_WIDTH, BRAM write data.
- bram_rdata, input, DATA_WIDTH, BRAM read data.
- busy, output, 1, any read in flight or lock held.

Behaviour:
- Reset (reset=0, asynchronous):
  - Registered outputs clear: bram_en, bram_we, bram_addr, bram_wdata, rsp_valid, rsp_data, busy all 0.
  - Round-robin pointer = 0, lock cleared, read tag pipeline cleared.
  - req_ready is forced to 0 while reset is asserted.
- Arbitration (combinational, same cycle):
  - At most one req_ready bit is high.
  - Winner = first i with req_valid[i]=1, searching i = ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Pointer update: on a handshake by requester i, ptr <= (i+1) mod NUM_REQ. No handshake: ptr holds.
- Lock:
  - Handshake by i with req_lock[i]=1 sets lock_owner=i and locked=1.
  - While locked, only lock_owner is eligible. Other requesters see req_ready=0 even when the owner is idle.
  - locked clears at any clock edge where req_lock[lock_owner]=0. The owner's access in that cycle (its last beat) is still granted.
  - ptr is updated normally on every owner beat.
- BRAM drive: a handshake in cycle t registers bram_en=1, bram_we=req_we[i], bram_addr and bram_wdata from slice i; these are visible in cycle t+1. No handshake: bram_en=0, bram_we=0, and addr/wdata hold their last values.
- Read return:
  - Each read handshake pushes {valid, id} into a tag shift register of depth 1+READ_LATENCY.
  - rsp_valid[id] pulses 1 cycle in cycle t+1+READ_LATENCY.
  - rsp_data is registered from bram_rdata and aligned to rsp_valid.
  - Writes produce no response.
- Throughput: one access per cycle sustained, including back-to-back accesses by one requester. Responses are returned in issue order.
- Ordering: write at t followed by read of the same address at t+1 returns the new data, because the BRAM is sequential.
- busy = locked OR any tag-pipeline valid, registered.
- Mid-operation reset: in-flight responses are discarded (rsp_valid stays 0) and the lock is dropped.
- Out-of-range: req_addr slices are passed through unchecked. NUM_REQ=1 degenerates to a pass-through with 1-cycle registration.

Test Plan:
- Reset asserted with random req_valid -> req_ready=0, bram_en=0, rsp_valid=0. After release, ptr=0.
- Req 1 reads addr 5 (BRAM holds 0x3C), READ_LATENCY=1 -> bram_en=1/addr=5 at t+1; rsp_valid=3'b010 and rsp_data=0x3C at t+2.
- All three requesters valid continuously, ptr=0 -> grant order 0,1,2,0,1,2; one bram_en per cycle; no gaps.
- Req 0 issues a 4-write burst with req_lock=1,1,1,0 while req 2 is valid -> req 2 gets no ready for 4 cycles, then is granted on the 5th; busy=1 during the burst.
- Req 2 writes 0x7F to addr 9 at t, req 1 reads addr 9 at t+1 -> rsp_valid[1] with 0x7F at t+3. READ_LATENCY=2 variant -> response at t+4.
- Two reads outstanding, then reset pulsed low for 1 cycle -> no rsp_valid after reset, locked=0, the next grant goes to the lowest valid index.
